// File: rtl/dezigzag_rowbuffer64x8bit_if.sv
// Coefficient-in / row-out handshake bundle for the de-zigzag row buffer.
// master: upstream coefficient source plus downstream row sink.
// slave: the row buffer itself.
interface dezigzag_rowbuffer64x8bit_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                    coef_valid;
  logic [DATA_WIDTH-1:0]   coef_data;
  logic                    coef_last;
  logic                    coef_ready;
  logic                    row_valid;
  logic                    row_ready;
  logic [7:0]              matrix_row;
  logic [8*DATA_WIDTH-1:0] row_data;
  logic                    block_done;
  logic                    len_err;

  modport master (
    output coef_valid, coef_data, coef_last, row_ready,
    input  coef_ready, row_valid, matrix_row, row_data, block_done, len_err
  );

  modport slave (
    input  coef_valid, coef_data, coef_last, row_ready,
    output coef_ready, row_valid, matrix_row, row_data, block_done, len_err
  );
endinterface

// File: rtl/dezigzag_rowbuffer64x8bit.sv
// De-zigzag row buffer: collects one 8x8 block of coefficients in JPEG
// zigzag scan order, stores each at its natural raster position, then
// emits the block as eight 8-coefficient rows. An early coef_last leaves
// the remaining positions at zero; a block that runs to 64 coefficients
// without coef_last closes anyway and raises the sticky len_err flag.
module dezigzag_rowbuffer64x8bit #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 64
) (
  input logic                       clock,
  input logic                       reset,
  dezigzag_rowbuffer64x8bit_if.slave bus
);

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  // Scan index k -> natural (row*8 + col) position.
  localparam logic [5:0] ZZ [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10,
    17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34,
    27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36,
    29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46,
    53, 60, 61, 54, 47, 55, 62, 63
  };

  localparam logic [5:0] K_LAST   = 6'(DEPTH - 1);
  localparam logic [7:0] ROW_LAST = 8'd7;

  state_t                  state;
  logic [5:0]              k;
  logic [7:0]              matrix_row;
  logic                    coef_ready;
  logic                    row_valid;
  logic                    block_done;
  logic                    len_err;
  logic [DATA_WIDTH-1:0]   buf_mem [DEPTH];
  logic [8*DATA_WIDTH-1:0] row_data;

  logic accept;
  logic close_block;
  logic row_xfer;
  logic last_row_xfer;

  // Handshake qualifiers shared by the FSM and the buffer.
  always_comb begin
    accept        = bus.coef_valid && coef_ready;
    close_block   = accept && (bus.coef_last || (k == K_LAST));
    row_xfer      = row_valid && bus.row_ready;
    last_row_xfer = row_xfer && (matrix_row == ROW_LAST);
  end

  // Fill/drain sequencing with registered handshake outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= FILL;
      k          <= '0;
      matrix_row <= '0;
      coef_ready <= 1'b1;
      row_valid  <= 1'b0;
      block_done <= 1'b0;
      len_err    <= 1'b0;
    end else begin
      block_done <= 1'b0;
      case (state)
        FILL: begin
          if (accept) begin
            if (close_block) begin
              state      <= DRAIN;
              k          <= '0;
              matrix_row <= '0;
              coef_ready <= 1'b0;
              row_valid  <= 1'b1;
              if (!bus.coef_last) begin
                len_err <= 1'b1;
              end
            end else begin
              k <= k + 6'd1;
            end
          end
        end
        DRAIN: begin
          if (row_xfer) begin
            if (last_row_xfer) begin
              state      <= FILL;
              matrix_row <= '0;
              coef_ready <= 1'b1;
              row_valid  <= 1'b0;
              block_done <= 1'b1;
            end else begin
              matrix_row <= matrix_row + 8'd1;
            end
          end
        end
        default: begin
          state      <= FILL;
          coef_ready <= 1'b1;
          row_valid  <= 1'b0;
        end
      endcase
    end
  end

  // Coefficient storage; cleared after the last row so the next block starts zero-filled.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        buf_mem[i] <= '0;
      end
    end else if (last_row_xfer) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        buf_mem[i] <= '0;
      end
    end else if (accept) begin
      buf_mem[ZZ[k]] <= bus.coef_data;
    end
  end

  // Row selected by matrix_row, column c in bits [8c+7:8c].
  always_comb begin
    row_data = '0;
    for (int unsigned c = 0; c < 8; c++) begin
      row_data[c*DATA_WIDTH +: DATA_WIDTH] = buf_mem[{matrix_row[2:0], 3'(c)}];
    end
  end

  assign bus.coef_ready = coef_ready;
  assign bus.row_valid  = row_valid;
  assign bus.matrix_row = matrix_row;
  assign bus.row_data   = row_data;
  assign bus.block_done = block_done;
  assign bus.len_err    = len_err;

endmodule

// File: tb/tb_dezigzag_rowbuffer64x8bit.sv
// Directed bench for the de-zigzag row buffer: reset state, a full
// in-order block, an early-EOB block, downstream backpressure, a block
// missing coef_last, and asynchronous reset mid-drain.
module tb_dezigzag_rowbuffer64x8bit;

  logic clock;
  logic reset;
  int   checks;
  int   fails;

  dezigzag_rowbuffer64x8bit_if #(.DATA_WIDTH(8)) bus ();

  dezigzag_rowbuffer64x8bit #(.DATA_WIDTH(8), .DEPTH(64)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Natural-order rows for a block whose coefficient k carries value k.
  localparam logic [63:0] FULL_ROWS [8] = '{
    64'h1C1B0F0E06050100,
    64'h2A1D1A100D070402,
    64'h2B291E19110C0803,
    64'h352C281F18120B09,
    64'h36342D272017130A,
    64'h3C37332E26211614,
    64'h3D3B38322F252215,
    64'h3F3E3A3931302423
  };

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [7:0] data, input logic last);
    bus.coef_valid = 1'b1;
    bus.coef_data  = data;
    bus.coef_last  = last;
    step();
    bus.coef_valid = 1'b0;
    bus.coef_last  = 1'b0;
  endtask

  task automatic test_reset();
    reset          = 1'b1;
    bus.coef_valid = 1'b0;
    bus.coef_data  = '0;
    bus.coef_last  = 1'b0;
    bus.row_ready  = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    step();
    checks++; if (bus.coef_ready !== 1'b1) begin fails++; $display("FAIL reset_coef_ready: got %b want 1", bus.coef_ready); end
    checks++; if (bus.row_valid !== 1'b0) begin fails++; $display("FAIL reset_row_valid: got %b want 0", bus.row_valid); end
    checks++; if (bus.matrix_row !== 8'd0) begin fails++; $display("FAIL reset_matrix_row: got %0d want 0", bus.matrix_row); end
    checks++; if (bus.row_data !== 64'd0) begin fails++; $display("FAIL reset_row_data: got %h want 0", bus.row_data); end
    checks++; if (bus.len_err !== 1'b0) begin fails++; $display("FAIL reset_len_err: got %b want 0", bus.len_err); end
    checks++; if (bus.block_done !== 1'b0) begin fails++; $display("FAIL reset_block_done: got %b want 0", bus.block_done); end
  endtask

  task automatic test_full_block();
    bus.row_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      checks++; if (bus.coef_ready !== 1'b1) begin fails++; $display("FAIL full_fill_ready k=%0d: got %b want 1", i, bus.coef_ready); end
      push(8'(i), i == 63);
    end
    checks++; if (bus.row_valid !== 1'b1) begin fails++; $display("FAIL full_row_valid: got %b want 1", bus.row_valid); end
    for (int r = 0; r < 8; r++) begin
      checks++; if (bus.matrix_row !== 8'(r)) begin fails++; $display("FAIL full_matrix_row: got %0d want %0d", bus.matrix_row, r); end
      checks++; if (bus.row_data !== FULL_ROWS[r]) begin fails++; $display("FAIL full_row%0d: got %h want %h", r, bus.row_data, FULL_ROWS[r]); end
      checks++; if (bus.block_done !== 1'b0) begin fails++; $display("FAIL full_done_early row %0d: got %b want 0", r, bus.block_done); end
      step();
    end
    checks++; if (bus.block_done !== 1'b1) begin fails++; $display("FAIL full_block_done: got %b want 1", bus.block_done); end
    checks++; if (bus.row_valid !== 1'b0) begin fails++; $display("FAIL full_back_to_fill: row_valid got %b want 0", bus.row_valid); end
    checks++; if (bus.coef_ready !== 1'b1) begin fails++; $display("FAIL full_coef_ready_after: got %b want 1", bus.coef_ready); end
    checks++; if (bus.row_data !== 64'd0) begin fails++; $display("FAIL full_buffer_cleared: got %h want 0", bus.row_data); end
    checks++; if (bus.len_err !== 1'b0) begin fails++; $display("FAIL full_len_err: got %b want 0", bus.len_err); end
    step();
    checks++; if (bus.block_done !== 1'b0) begin fails++; $display("FAIL full_done_pulse_width: got %b want 0", bus.block_done); end
  endtask

  task automatic test_eob();
    logic [63:0] exp_row;
    bus.row_ready = 1'b0;
    push(8'h11, 1'b0);
    push(8'h22, 1'b0);
    push(8'h33, 1'b1);
    checks++; if (bus.row_valid !== 1'b1) begin fails++; $display("FAIL eob_row_valid: got %b want 1", bus.row_valid); end
    checks++; if (bus.coef_ready !== 1'b0) begin fails++; $display("FAIL eob_coef_ready: got %b want 0", bus.coef_ready); end
    // Coefficients offered during the drain must be ignored.
    bus.coef_valid = 1'b1;
    bus.coef_data  = 8'hEE;
    bus.coef_last  = 1'b0;
    step();
    bus.row_ready = 1'b1;
    for (int r = 0; r < 8; r++) begin
      exp_row = (r == 0) ? 64'h0000000000002211 : (r == 1) ? 64'h0000000000000033 : 64'd0;
      checks++; if (bus.row_data !== exp_row) begin fails++; $display("FAIL eob_row%0d: got %h want %h", r, bus.row_data, exp_row); end
      if (r == 7) bus.coef_valid = 1'b0;
      step();
    end
    checks++; if (bus.block_done !== 1'b1) begin fails++; $display("FAIL eob_block_done: got %b want 1", bus.block_done); end
    checks++; if (bus.len_err !== 1'b0) begin fails++; $display("FAIL eob_len_err: got %b want 0", bus.len_err); end
  endtask

  task automatic test_backpressure();
    bus.row_ready = 1'b0;
    for (int i = 0; i < 64; i++) push(8'(i), i == 63);
    bus.row_ready = 1'b1;
    step();
    step();
    bus.row_ready  = 1'b0;
    bus.coef_valid = 1'b1;
    bus.coef_data  = 8'hAA;
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.matrix_row !== 8'd2) begin fails++; $display("FAIL stall_matrix_row cyc %0d: got %0d want 2", i, bus.matrix_row); end
      checks++; if (bus.row_data !== FULL_ROWS[2]) begin fails++; $display("FAIL stall_row_data cyc %0d: got %h want %h", i, bus.row_data, FULL_ROWS[2]); end
      checks++; if (bus.coef_ready !== 1'b0) begin fails++; $display("FAIL stall_coef_ready cyc %0d: got %b want 0", i, bus.coef_ready); end
      step();
    end
    bus.coef_valid = 1'b0;
    bus.row_ready  = 1'b1;
    for (int r = 2; r < 8; r++) begin
      checks++; if (bus.row_data !== FULL_ROWS[r]) begin fails++; $display("FAIL stall_resume_row%0d: got %h want %h", r, bus.row_data, FULL_ROWS[r]); end
      step();
    end
    checks++; if (bus.block_done !== 1'b1) begin fails++; $display("FAIL stall_block_done: got %b want 1", bus.block_done); end
  endtask

  task automatic test_len_err();
    bus.row_ready = 1'b0;
    for (int i = 0; i < 63; i++) push(8'(63 - i), 1'b0);
    checks++; if (bus.coef_ready !== 1'b1) begin fails++; $display("FAIL len_still_fill: coef_ready got %b want 1", bus.coef_ready); end
    checks++; if (bus.len_err !== 1'b0) begin fails++; $display("FAIL len_err_early: got %b want 0", bus.len_err); end
    push(8'd0, 1'b0);
    checks++; if (bus.row_valid !== 1'b1) begin fails++; $display("FAIL len_drain_entered: row_valid got %b want 1", bus.row_valid); end
    checks++; if (bus.len_err !== 1'b1) begin fails++; $display("FAIL len_err_set: got %b want 1", bus.len_err); end
    checks++; if (bus.row_data !== 64'h23243031393A3E3F) begin fails++; $display("FAIL len_row0: got %h want 23243031393a3e3f", bus.row_data); end
    bus.row_ready = 1'b1;
    for (int r = 0; r < 8; r++) begin
      if (r == 7) begin
        checks++; if (bus.row_data !== 64'h000105060E0F1B1C) begin fails++; $display("FAIL len_row7: got %h want 000105060e0f1b1c", bus.row_data); end
      end
      step();
    end
    push(8'h7F, 1'b1);
    checks++; if (bus.row_data !== 64'h000000000000007F) begin fails++; $display("FAIL len_next_row0: got %h want 7f", bus.row_data); end
    checks++; if (bus.len_err !== 1'b1) begin fails++; $display("FAIL len_err_sticky: got %b want 1", bus.len_err); end
    repeat (8) step();
    checks++; if (bus.len_err !== 1'b1) begin fails++; $display("FAIL len_err_after_block: got %b want 1", bus.len_err); end
  endtask

  task automatic test_async_reset();
    bus.row_ready = 1'b1;
    for (int i = 0; i < 64; i++) push(8'(i), i == 63);
    repeat (3) step();
    checks++; if (bus.matrix_row !== 8'd3) begin fails++; $display("FAIL areset_pre_row: got %0d want 3", bus.matrix_row); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (bus.row_valid !== 1'b0) begin fails++; $display("FAIL areset_row_valid: got %b want 0", bus.row_valid); end
    checks++; if (bus.coef_ready !== 1'b1) begin fails++; $display("FAIL areset_coef_ready: got %b want 1", bus.coef_ready); end
    checks++; if (bus.matrix_row !== 8'd0) begin fails++; $display("FAIL areset_matrix_row: got %0d want 0", bus.matrix_row); end
    checks++; if (bus.row_data !== 64'd0) begin fails++; $display("FAIL areset_row_data: got %h want 0", bus.row_data); end
    checks++; if (bus.len_err !== 1'b0) begin fails++; $display("FAIL areset_len_err: got %b want 0", bus.len_err); end
    @(negedge clock);
    reset = 1'b0;
    step();
    checks++; if (bus.block_done !== 1'b0) begin fails++; $display("FAIL areset_no_done: got %b want 0", bus.block_done); end
    for (int i = 0; i < 64; i++) push(8'd0, i == 63);
    checks++; if (bus.row_valid !== 1'b1) begin fails++; $display("FAIL areset_next_valid: got %b want 1", bus.row_valid); end
    for (int r = 0; r < 8; r++) begin
      checks++; if (bus.row_data !== 64'd0) begin fails++; $display("FAIL areset_zero_row%0d: got %h want 0", r, bus.row_data); end
      step();
    end
    checks++; if (bus.block_done !== 1'b1) begin fails++; $display("FAIL areset_block_done: got %b want 1", bus.block_done); end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    test_reset();
    test_full_block();
    test_eob();
    test_backpressure();
    test_len_err();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/dezigzag_rowbuffer64x8bit.md
DEZIGZAG_ROWBUFFER64X8BIT -- requirements
Module: dezigzag_rowbuffer64x8bit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, coefficient width in bits.
REQ-002 SHALL have parameter DEPTH, default 64, coefficients per 8x8 block.
REQ-003 SHALL have port clock  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port coef_valid  input  1  coef_data is valid this cycle.
REQ-006 SHALL have port coef_data  input  DATA_WIDTH  coefficient in zigzag scan order.
REQ-007 SHALL have port coef_last  input  1  final coefficient of block (EOB marker).
REQ-008 SHALL have port coef_ready  output  1  block accepts a coefficient this cycle.
REQ-009 SHALL have port row_valid  output  1  row_data/matrix_row valid.
REQ-010 SHALL have port row_ready  input  1  downstream accepts the row.
REQ-011 SHALL have port matrix_row  output  8  natural-order row index, 0..7.
REQ-012 SHALL have port row_data  output  64  row pixels; column c in bits [8c+7:8c].
REQ-013 SHALL have port block_done  output  1  one-cycle pulse after row 7 transfers.
REQ-014 SHALL have port len_err  output  1  sticky: block closed at 64 coefficients without coef_last.

Function
REQ-015 SHALL implement a two-state FSM: FILL (coef_ready=1, row_valid=0), DRAIN (coef_ready=0, row_valid=1).
REQ-016 SHALL accept a coefficient only on coef_valid && coef_ready; a 6-bit scan index k (reset 0) counts accepted coefficients.
REQ-017 SHALL write an accepted coefficient to natural position zz[k] of the 64x8 buffer, zz being the standard JPEG zigzag table (k 0..9 -> 0,1,8,16,9,2,3,10,17,24; k 63 -> 63).
REQ-018 SHALL leave FILL for DRAIN on the edge accepting coef_last or the coefficient with k=63, whichever comes first; k returns to 0.
REQ-019 SHALL leave unwritten positions at zero when coef_last ends a block early (EOB zero-fill).
REQ-020 SHALL set len_err on the edge accepting k=63 with coef_last=0; only reset clears it.
REQ-021 SHALL assert row_valid starting the cycle after the closing edge with matrix_row=0.
REQ-022 SHALL drive row_data combinationally from the buffer row selected by matrix_row.
REQ-023 SHALL hold matrix_row and row_data stable while row_valid && !row_ready.
REQ-024 SHALL advance matrix_row by 1 on each row_valid && row_ready edge.
REQ-025 SHALL, on the row-7 transfer edge: clear the whole buffer to zero, set matrix_row to 0, enter FILL, and pulse block_done high for the next cycle only.
REQ-026 SHALL reach minimum throughput of 64+8 cycles per block with coef_valid and row_ready held high; no coefficient is accepted during DRAIN.
REQ-027 SHALL ignore coef_last when coef_valid is 0, and ignore coef_data/coef_last in DRAIN.

Reset
REQ-028 SHALL, while reset=1 and independent of clock: set state FILL, k=0, matrix_row=0, buffer all zero, block_done=0, len_err=0, row_valid=0, coef_ready=1.
REQ-029 SHALL abandon any partially filled or partially drained block on reset, with no block_done pulse.

Verification
REQ-030 SHALL cover: reset release -> coef_ready=1, row_valid=0, matrix_row=0, row_data=0, len_err=0.
REQ-031 SHALL cover: coef_data=k for k=0..63, coef_last at k=63, row_ready=1 -> row 0 = 64'h1C1B0F0E06050100, row 1 = 64'h2A1D1A100D070402, row 7 MSB byte 0x3F, block_done one cycle after row 7, len_err=0.
REQ-032 SHALL cover: EOB block 0x11,0x22,0x33 with coef_last on 0x33 -> row 0 = 64'h0000000000002211, row 1 = 64'h0000000000000033, rows 2..7 = 0, row_valid from next cycle.
REQ-033 SHALL cover: row_ready low 5 cycles during DRAIN row 2 -> matrix_row=2 and row_data unchanged all 5 cycles, coef_ready=0 throughout.
REQ-034 SHALL cover: 64 coefficients without coef_last -> DRAIN entered after the 64th, len_err=1 persisting through the next block.
REQ-035 SHALL cover: reset asserted asynchronously during DRAIN at matrix_row=3 -> row_valid=0 immediately, after release next block with all-zero coefficients yields rows all zero.
